// File: rtl/alu_sequencer_if.sv
// Bundle of request, ALU-drive, ALU-return and response signals for the ALU sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface alu_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_fn;
  logic [7:0] req_acc;
  logic [7:0] req_mem;
  logic       d_flag;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [9:0] alu_tristate_controls;
  logic [9:0] alu_tristate_controls_b;
  logic       alu_c_in;
  logic       alu_bcd;

  logic [7:0] alu_y;
  logic       alu_zero;
  logic       alu_negative;
  logic       alu_overflow;
  logic       alu_c_out;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic       p_n;
  logic       p_v;
  logic       p_z;
  logic       p_c;

  modport slave (
    input  req_valid, req_fn, req_acc, req_mem, d_flag,
    output req_ready,
    output alu_a, alu_b, alu_op, alu_tristate_controls, alu_tristate_controls_b,
    output alu_c_in, alu_bcd,
    input  alu_y, alu_zero, alu_negative, alu_overflow, alu_c_out,
    output rsp_valid, rsp_y, p_n, p_v, p_z, p_c,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_fn, req_acc, req_mem, d_flag,
    input  req_ready,
    input  alu_a, alu_b, alu_op, alu_tristate_controls, alu_tristate_controls_b,
    input  alu_c_in, alu_bcd,
    output alu_y, alu_zero, alu_negative, alu_overflow, alu_c_out,
    input  rsp_valid, rsp_y, p_n, p_v, p_z, p_c,
    output rsp_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one 6502-style ALU operation per request over an external ALU,
// with an optional second pass that applies the BCD correction for ADC/SBC.
module alu_sequencer (
  input logic            ph1,
  input logic            resetb,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, ADJ, RESP} state_t;

  localparam logic [3:0] FN_ADC = 4'd0;
  localparam logic [3:0] FN_SBC = 4'd1;
  localparam logic [3:0] FN_INC = 4'd2;
  localparam logic [3:0] FN_DEC = 4'd3;
  localparam logic [3:0] FN_ASL = 4'd4;
  localparam logic [3:0] FN_LSR = 4'd5;
  localparam logic [3:0] FN_ROL = 4'd6;
  localparam logic [3:0] FN_ROR = 4'd7;
  localparam logic [3:0] FN_ORA = 4'd8;
  localparam logic [3:0] FN_AND = 4'd9;
  localparam logic [3:0] FN_EOR = 4'd10;
  localparam logic [3:0] FN_CMP = 4'd11;
  localparam logic [3:0] FN_BIT = 4'd12;
  localparam logic [3:0] FN_SEC = 4'd13;
  localparam logic [3:0] FN_CLC = 4'd14;

  localparam logic [9:0] TS_ARITH = 10'h200;
  localparam logic [9:0] TS_ROR   = 10'h100;
  localparam logic [9:0] TS_ASL   = 10'h080;
  localparam logic [9:0] TS_ROL   = 10'h040;
  localparam logic [9:0] TS_OR    = 10'h020;
  localparam logic [9:0] TS_AND   = 10'h010;
  localparam logic [9:0] TS_EOR   = 10'h004;

  state_t     state_q;
  logic [3:0] fn_q;
  logic [7:0] acc_q;
  logic [7:0] mem_q;
  logic       dec_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [3:0] alu_op_q;
  logic [9:0] ctrl_q;
  logic       alu_c_in_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_y_q;
  logic       p_n_q;
  logic       p_v_q;
  logic       p_z_q;
  logic       p_c_q;

  // ALU drive for the EXEC cycle, decoded from the incoming request
  logic [9:0] ctrl_d;
  logic [3:0] alu_op_d;
  logic [7:0] alu_a_d;
  logic [7:0] alu_b_d;
  logic       alu_c_in_d;

  always_comb begin
    ctrl_d     = '0;
    alu_op_d   = '0;
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_c_in_d = 1'b0;
    case (bus.req_fn)
      FN_ADC, FN_SBC, FN_CMP: begin
        ctrl_d     = TS_ARITH;
        alu_op_d   = (bus.req_fn == FN_ADC) ? 4'd2 : 4'd3;
        alu_a_d    = bus.req_mem;
        alu_b_d    = bus.req_acc;
        alu_c_in_d = (bus.req_fn == FN_CMP) ? 1'b1 : p_c_q;
      end
      FN_INC, FN_DEC: begin
        ctrl_d     = TS_ARITH;
        alu_op_d   = (bus.req_fn == FN_INC) ? 4'd0 : 4'd1;
        alu_a_d    = bus.req_mem;
        alu_c_in_d = 1'b1;
      end
      FN_ASL: begin
        ctrl_d  = TS_ASL;
        alu_a_d = bus.req_mem;
      end
      FN_LSR: begin
        ctrl_d  = TS_ROR;
        alu_a_d = bus.req_mem;
      end
      FN_ROL, FN_ROR: begin
        ctrl_d     = (bus.req_fn == FN_ROL) ? TS_ROL : TS_ROR;
        alu_a_d    = bus.req_mem;
        alu_c_in_d = p_c_q;
      end
      FN_ORA, FN_AND, FN_EOR, FN_BIT: begin
        ctrl_d  = (bus.req_fn == FN_ORA) ? TS_OR :
                  (bus.req_fn == FN_EOR) ? TS_EOR : TS_AND;
        alu_a_d = bus.req_acc;
        alu_b_d = bus.req_mem;
      end
      default: ;
    endcase
  end

  // BCD correction, judged from the pass-1 result and the registered operands
  logic       is_sbc;
  logic       is_arith2;
  logic [4:0] half_add;
  logic [4:0] half_sub;
  logic       lo_fix;
  logic       hi_fix;
  logic [7:0] corr;
  logic       c_final;

  always_comb begin
    is_sbc    = (fn_q == FN_SBC);
    is_arith2 = (fn_q == FN_ADC) || is_sbc;
    half_add  = {1'b0, acc_q[3:0]} + {1'b0, mem_q[3:0]} + {4'd0, alu_c_in_q};
    half_sub  = {1'b0, acc_q[3:0]} + {1'b0, ~mem_q[3:0]} + {4'd0, alu_c_in_q};
    // A missing nibble carry in the ~a+b+c form is a half-borrow
    lo_fix    = is_sbc ? ~half_sub[4] : (half_add[4] | (bus.alu_y[3:0] > 4'd9));
    hi_fix    = is_sbc ? ~bus.alu_c_out : (bus.alu_c_out | (bus.alu_y > 8'h99));
    corr      = {(hi_fix ? 4'h6 : 4'h0), (lo_fix ? 4'h6 : 4'h0)};
    c_final   = (is_sbc || !dec_q) ? bus.alu_c_out : (bus.alu_c_out | hi_fix);
  end

  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      fn_q        <= '0;
      acc_q       <= '0;
      mem_q       <= '0;
      dec_q       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      ctrl_q      <= '0;
      alu_c_in_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      p_n_q       <= 1'b0;
      p_v_q       <= 1'b0;
      p_z_q       <= 1'b0;
      p_c_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            fn_q       <= bus.req_fn;
            acc_q      <= bus.req_acc;
            mem_q      <= bus.req_mem;
            dec_q      <= bus.d_flag;
            ctrl_q     <= ctrl_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_c_in_q <= alu_c_in_d;
            state_q    <= EXEC;
          end
        end

        EXEC: begin
          case (fn_q)
            FN_ADC, FN_SBC: begin
              rsp_y_q <= bus.alu_y;
              p_n_q   <= bus.alu_negative;
              p_v_q   <= bus.alu_overflow;
              p_z_q   <= bus.alu_zero;
              p_c_q   <= c_final;
            end
            FN_INC, FN_DEC, FN_ORA, FN_AND, FN_EOR: begin
              rsp_y_q <= bus.alu_y;
              p_n_q   <= bus.alu_negative;
              p_z_q   <= bus.alu_zero;
            end
            FN_ASL, FN_LSR, FN_ROL, FN_ROR: begin
              rsp_y_q <= bus.alu_y;
              p_n_q   <= bus.alu_negative;
              p_z_q   <= bus.alu_zero;
              p_c_q   <= bus.alu_c_out;
            end
            FN_CMP: begin
              rsp_y_q <= acc_q;
              p_n_q   <= bus.alu_negative;
              p_z_q   <= bus.alu_zero;
              p_c_q   <= bus.alu_c_out;
            end
            FN_BIT: begin
              rsp_y_q <= acc_q;
              p_n_q   <= mem_q[7];
              p_v_q   <= mem_q[6];
              p_z_q   <= bus.alu_zero;
            end
            FN_SEC: begin
              rsp_y_q <= acc_q;
              p_c_q   <= 1'b1;
            end
            FN_CLC: begin
              rsp_y_q <= acc_q;
              p_c_q   <= 1'b0;
            end
            default: rsp_y_q <= acc_q;
          endcase

          if (is_arith2 && dec_q) begin
            // Second pass keeps the arithmetic control and opcode of pass 1
            alu_a_q    <= corr;
            alu_b_q    <= bus.alu_y;
            alu_c_in_q <= is_sbc;
            state_q    <= ADJ;
          end else begin
            ctrl_q      <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_c_in_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end

        ADJ: begin
          rsp_y_q     <= bus.alu_y;
          ctrl_q      <= '0;
          alu_op_q    <= '0;
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_c_in_q  <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready               = (state_q == IDLE);
  assign bus.alu_a                   = alu_a_q;
  assign bus.alu_b                   = alu_b_q;
  assign bus.alu_op                  = alu_op_q;
  assign bus.alu_tristate_controls   = ctrl_q;
  assign bus.alu_tristate_controls_b = ~ctrl_q;
  assign bus.alu_c_in                = alu_c_in_q;
  assign bus.alu_bcd                 = 1'b0;
  assign bus.rsp_valid               = rsp_valid_q;
  assign bus.rsp_y                   = rsp_y_q;
  assign bus.p_n                     = p_n_q;
  assign bus.p_v                     = p_v_q;
  assign bus.p_z                     = p_z_q;
  assign bus.p_c                     = p_c_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the external ALU.
module tb_alu_sequencer;

  logic ph1;
  logic resetb;
  int   checks;
  int   failures;
  int   lat;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .ph1    (ph1),
    .resetb (resetb),
    .bus    (bus)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  // External ALU: one-hot tristate select, subtract is ~a + b + c_in
  logic [8:0] alu_r;
  logic       alu_v;
  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    if (bus.alu_tristate_controls[9]) begin
      case (bus.alu_op)
        4'd0: alu_r = {1'b0, bus.alu_a} + {8'd0, bus.alu_c_in};
        4'd1: alu_r = {1'b0, bus.alu_a} - {8'd0, bus.alu_c_in};
        4'd2: begin
          alu_r = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_c_in};
          alu_v = (bus.alu_a[7] == bus.alu_b[7]) && (alu_r[7] != bus.alu_a[7]);
        end
        4'd3: begin
          alu_r = {1'b0, ~bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_c_in};
          alu_v = (~bus.alu_a[7] == bus.alu_b[7]) && (alu_r[7] != ~bus.alu_a[7]);
        end
        default: ;
      endcase
    end else if (bus.alu_tristate_controls[8]) alu_r = {bus.alu_a[0], bus.alu_c_in, bus.alu_a[7:1]};
    else if (bus.alu_tristate_controls[7]) alu_r = {bus.alu_a, 1'b0};
    else if (bus.alu_tristate_controls[6]) alu_r = {bus.alu_a, bus.alu_c_in};
    else if (bus.alu_tristate_controls[5]) alu_r = {1'b0, bus.alu_a | bus.alu_b};
    else if (bus.alu_tristate_controls[4]) alu_r = {1'b0, bus.alu_a & bus.alu_b};
    else if (bus.alu_tristate_controls[2]) alu_r = {1'b0, bus.alu_a ^ bus.alu_b};
  end
  assign bus.alu_y        = alu_r[7:0];
  assign bus.alu_c_out    = alu_r[8];
  assign bus.alu_zero     = (alu_r[7:0] == 8'h00);
  assign bus.alu_negative = alu_r[7];
  assign bus.alu_overflow = alu_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] nvzc);
    check(tag, {28'd0, bus.p_n, bus.p_v, bus.p_z, bus.p_c}, {28'd0, nvzc});
  endtask

  // Issue one request and wait (bounded) for rsp_valid; lat counts edges incl. the accept edge
  task automatic do_req(input logic [3:0] fn, input logic [7:0] acc, input logic [7:0] mem,
                        input logic d, output int lat_o);
    @(negedge ph1);
    check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_fn    = fn;
    bus.req_acc   = acc;
    bus.req_mem   = mem;
    bus.d_flag    = d;
    @(posedge ph1);
    #1;
    bus.req_valid = 1'b0;
    lat_o = 1;
    while (!bus.rsp_valid && lat_o < 20) begin
      @(posedge ph1);
      #1;
      lat_o++;
    end
    check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    $display("txn fn=%0d acc=%02h mem=%02h d=%0d -> y=%02h nvzc=%b%b%b%b lat=%0d",
             fn, acc, mem, d, bus.rsp_y, bus.p_n, bus.p_v, bus.p_z, bus.p_c, lat_o);
  endtask

  task automatic finish_rsp();
    @(negedge ph1);
    bus.rsp_ready = 1'b1;
    @(posedge ph1);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rsp_done_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    resetb        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_fn    = '0;
    bus.req_acc   = '0;
    bus.req_mem   = '0;
    bus.d_flag    = 1'b0;
    bus.rsp_ready = 1'b0;

    #1;
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_y", {24'd0, bus.rsp_y}, 32'h00);
    check_flags("rst_flags", 4'b0000);
    check("rst_ctrl", {22'd0, bus.alu_tristate_controls}, 32'h000);
    check("rst_ctrl_b", {22'd0, bus.alu_tristate_controls_b}, 32'h3FF);
    check("rst_alu_ab", {16'd0, bus.alu_a, bus.alu_b}, 32'h0000);
    repeat (2) @(posedge ph1);
    @(negedge ph1);
    resetb = 1'b1;
    @(posedge ph1);
    #1;
    check("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

    // Binary ADC with signed overflow
    do_req(4'd0, 8'h50, 8'h50, 1'b0, lat);
    check("adc_bin_lat", lat, 2);
    check("adc_bin_y", {24'd0, bus.rsp_y}, 32'hA0);
    check_flags("adc_bin_flags", 4'b1100);
    check("resp_ctrl", {22'd0, bus.alu_tristate_controls}, 32'h000);
    check("resp_bcd", {31'd0, bus.alu_bcd}, 32'd0);
    finish_rsp();

    do_req(4'd13, 8'h12, 8'h00, 1'b0, lat);
    check("sec_y", {24'd0, bus.rsp_y}, 32'h12);
    check_flags("sec_flags", 4'b1101);
    finish_rsp();

    // Decimal ADC 58+46+1 = 105
    do_req(4'd0, 8'h58, 8'h46, 1'b1, lat);
    check("adc_dec_lat", lat, 3);
    check("adc_dec_y", {24'd0, bus.rsp_y}, 32'h05);
    check_flags("adc_dec_flags", 4'b1101);
    finish_rsp();

    do_req(4'd1, 8'h00, 8'h01, 1'b0, lat);
    check("sbc_lat", lat, 2);
    check("sbc_y", {24'd0, bus.rsp_y}, 32'hFF);
    check_flags("sbc_flags", 4'b1000);
    finish_rsp();

    do_req(4'd0, 8'h50, 8'h50, 1'b0, lat);
    check_flags("adc_setv_flags", 4'b1100);
    finish_rsp();

    do_req(4'd11, 8'h40, 8'h40, 1'b0, lat);
    check("cmp_y", {24'd0, bus.rsp_y}, 32'h40);
    check_flags("cmp_flags", 4'b0111);
    finish_rsp();

    // ROR with the response held off; a stray request must be ignored
    do_req(4'd7, 8'h33, 8'h01, 1'b0, lat);
    bus.req_valid = 1'b1;
    bus.req_fn    = 4'd8;
    for (int i = 0; i < 5; i++) begin
      @(posedge ph1);
      #1;
      check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("hold_y", {24'd0, bus.rsp_y}, 32'h80);
      check("hold_ready", {31'd0, bus.req_ready}, 32'd0);
      check_flags("hold_flags", 4'b1101);
    end
    bus.req_valid = 1'b0;
    finish_rsp();

    do_req(4'd8, 8'h0F, 8'hF0, 1'b0, lat);
    check("ora_y", {24'd0, bus.rsp_y}, 32'hFF);
    check_flags("ora_flags", 4'b1101);
    finish_rsp();

    do_req(4'd9, 8'h0F, 8'hF0, 1'b0, lat);
    check("and_y", {24'd0, bus.rsp_y}, 32'h00);
    check_flags("and_flags", 4'b0111);
    finish_rsp();

    do_req(4'd10, 8'hFF, 8'h0F, 1'b0, lat);
    check("eor_y", {24'd0, bus.rsp_y}, 32'hF0);
    check_flags("eor_flags", 4'b1101);
    finish_rsp();

    do_req(4'd12, 8'h01, 8'hC0, 1'b0, lat);
    check("bit_y", {24'd0, bus.rsp_y}, 32'h01);
    check_flags("bit_flags", 4'b1111);
    finish_rsp();

    do_req(4'd2, 8'h00, 8'hFF, 1'b0, lat);
    check("inc_y", {24'd0, bus.rsp_y}, 32'h00);
    check_flags("inc_flags", 4'b0111);
    finish_rsp();

    do_req(4'd3, 8'h00, 8'h00, 1'b0, lat);
    check("dec_y", {24'd0, bus.rsp_y}, 32'hFF);
    check_flags("dec_flags", 4'b1101);
    finish_rsp();

    do_req(4'd4, 8'h00, 8'h81, 1'b0, lat);
    check("asl_y", {24'd0, bus.rsp_y}, 32'h02);
    check_flags("asl_flags", 4'b0101);
    finish_rsp();

    do_req(4'd5, 8'h00, 8'h01, 1'b0, lat);
    check("lsr_y", {24'd0, bus.rsp_y}, 32'h00);
    check_flags("lsr_flags", 4'b0111);
    finish_rsp();

    do_req(4'd6, 8'h00, 8'h80, 1'b0, lat);
    check("rol_y", {24'd0, bus.rsp_y}, 32'h01);
    check_flags("rol_flags", 4'b0101);
    finish_rsp();

    do_req(4'd14, 8'h77, 8'h00, 1'b0, lat);
    check("clc_y", {24'd0, bus.rsp_y}, 32'h77);
    check_flags("clc_flags", 4'b0100);
    finish_rsp();

    do_req(4'd15, 8'h5A, 8'h13, 1'b0, lat);
    check("nop_y", {24'd0, bus.rsp_y}, 32'h5A);
    check_flags("nop_flags", 4'b0100);
    finish_rsp();

    do_req(4'd13, 8'h00, 8'h00, 1'b0, lat);
    finish_rsp();

    // Decimal ADC interrupted by reset during the correction pass
    @(negedge ph1);
    bus.req_valid = 1'b1;
    bus.req_fn    = 4'd0;
    bus.req_acc   = 8'h58;
    bus.req_mem   = 8'h46;
    bus.d_flag    = 1'b1;
    @(posedge ph1);
    #1;
    bus.req_valid = 1'b0;
    check("exec_ctrl", {22'd0, bus.alu_tristate_controls}, 32'h200);
    @(posedge ph1);
    #1;
    check("adj_ctrl", {22'd0, bus.alu_tristate_controls}, 32'h200);
    check("adj_ctrl_b", {22'd0, bus.alu_tristate_controls_b}, 32'h1FF);
    check("adj_a_corr", {24'd0, bus.alu_a}, 32'h66);
    check("adj_b_pass1", {24'd0, bus.alu_b}, 32'h9F);
    check("adj_c_in", {31'd0, bus.alu_c_in}, 32'd0);
    resetb = 1'b0;
    #1;
    check("midrst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_flags("midrst_flags", 4'b0000);
    check("midrst_y", {24'd0, bus.rsp_y}, 32'h00);
    check("midrst_ctrl", {22'd0, bus.alu_tristate_controls}, 32'h000);
    check("midrst_ab", {16'd0, bus.alu_a, bus.alu_b}, 32'h0000);
    check("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge ph1);
    resetb = 1'b1;

    do_req(4'd0, 8'h01, 8'h02, 1'b0, lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_y", {24'd0, bus.rsp_y}, 32'h03);
    check_flags("post_rst_flags", 4'b0000);
    finish_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: ph1 in 1, sole clock, all state updates on rising edge; resetb in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: req_valid in 1, request present; req_ready out 1, sequencer can accept; req_fn in 4, function code (REQ-012); req_acc in 8, accumulator operand; req_mem in 8, memory/immediate operand; d_flag in 1, decimal mode.
REQ-003 SHALL have ALU-drive ports: alu_a out 8; alu_b out 8; alu_op out 4; alu_tristate_controls out 10, one-hot; alu_tristate_controls_b out 10; alu_c_in out 1; alu_bcd out 1, tied 0.
REQ-004 SHALL have ALU-return ports: alu_y in 8; alu_zero, alu_negative, alu_overflow, alu_c_out in 1 each.
REQ-005 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_y out 8, result; p_n, p_v, p_z, p_c out 1 each, registered status flags.

Function
REQ-006 SHALL implement states IDLE, EXEC, ADJ, RESP; req_ready SHALL be 1 only in IDLE.
REQ-007 SHALL accept a request on the rising edge where req_valid and req_ready are both 1, registering req_fn, req_acc, req_mem, d_flag, and moving IDLE->EXEC; req_valid outside IDLE SHALL be ignored.
REQ-008 In EXEC, SHALL drive the ALU per REQ-012 for one cycle and register alu_y and the ALU flags at the cycle's end; next state ADJ for ADC/SBC with registered d_flag=1, otherwise RESP.
REQ-009 In ADJ, SHALL run one ALU add (ADC) or sub (SBC) of the correction per REQ-014, register alu_y, then go to RESP.
REQ-010 In RESP, rsp_valid SHALL be 1 and rsp_y/flags stable; on rsp_ready=1 SHALL go to IDLE. Latency accept-edge to rsp_valid: 2 cycles binary, 3 cycles decimal.
REQ-011 Arithmetic uses the ALU subtract convention y = ~alu_a + alu_b + c_in: subtrahend on alu_a, minuend on alu_b.
REQ-012 Function codes, with tristate bit driven (bit9 arith, 8 ror, 7 asl, 6 rol, 5 or, 4 and, 2 eor):
- 0 ADC: bit9, op 2, a=mem, b=acc, c_in=p_c; sets N,V,Z,C.
- 1 SBC: bit9, op 3, a=mem, b=acc, c_in=p_c; sets N,V,Z,C.
- 2 INC / 3 DEC: bit9, op 0/1, a=mem, c_in=1; sets N,Z.
- 4 ASL: bit7, a=mem; 5 LSR: bit8, a=mem, c_in=0; 6 ROL: bit6, c_in=p_c; 7 ROR: bit8, c_in=p_c; shifts set N,Z,C.
- 8 ORA / 9 AND / 10 EOR: bits 5/4/2, a=acc, b=mem; set N,Z.
- 11 CMP: as SBC but c_in=1; sets N,Z,C; rsp_y=acc.
- 12 BIT: bit4, a=acc, b=mem; Z=alu_zero, N=mem[7], V=mem[6]; rsp_y=acc.
- 13 SEC / 14 CLC: no ALU cycle used (controls 0), p_c=1/0; rsp_y=acc.
- 15: no-op, flags unchanged, rsp_y=acc.
REQ-013 Flags not listed for a function SHALL hold their prior values.
REQ-014 Decimal: lo = nibble half-carry (ADC) or no half-borrow (SBC), computed internally from registered operands, or (ADC only) pass-1 y[3:0]>9; hi = ADC: pass-1 carry or pass-1 y>0x99; SBC: pass-1 C=0. Correction = {hi?6:0, lo?6:0}; a=correction, b=pass-1 y, c_in 0 (ADC) / 1 (SBC). Final C: ADC = pass-1 C | hi; SBC = pass-1 C. N,V,Z from pass 1.
REQ-015 alu_tristate_controls_b SHALL always equal ~alu_tristate_controls; outside EXEC/ADJ controls SHALL be 10'b0.

Reset
REQ-016 resetb=0 SHALL immediately force IDLE, rsp_valid=0, rsp_y=0, p_n=p_v=p_z=p_c=0, alu controls 0, alu_a=alu_b=0, regardless of state (including mid-ADJ).
REQ-017 req_ready SHALL be 1 on the first edge after resetb deasserts.

Verification
REQ-018 ADC acc=0x50 mem=0x50 C=0 D=0 -> rsp_valid 2 cycles after accept, rsp_y=0xA0, N=1 V=1 Z=0 C=0.
REQ-019 ADC acc=0x58 mem=0x46 C=1 D=1 -> rsp_valid after 3 cycles, rsp_y=0x05, C=1.
REQ-020 SBC acc=0x00 mem=0x01 C=1 D=0 -> rsp_y=0xFF, C=0, N=1, Z=0.
REQ-021 CMP acc=0x40 mem=0x40 -> Z=1 C=1 N=0, rsp_y=0x40, V unchanged.
REQ-022 ROR mem=0x01 C=1, rsp_ready held 0 for 5 cycles -> rsp_y=0x80 C=1 N=1 held stable, req_ready=0 until rsp_ready.
REQ-023 resetb pulsed low during ADJ -> rsp_valid=0, all flags 0 immediately; next request processed normally.
